// File: rtl/serial_parity_checker.sv
// rtl/serial_parity_checker.sv - receive end of the XOR parity serial link
//
// Deserialises LSB-first frames of DATA_W data bits followed by one parity
// bit, recomputes parity by XOR-accumulating the data bits and flags any
// mismatch. Saturating frame and error counters are kept for status/debug.
//
// Parameters:
//   DATA_W      data bits per frame (>= 2)
//   PARITY_ODD  0 = even parity expected, 1 = odd parity expected
//   CNT_W       width of frame_cnt and err_cnt
//
// Ports:
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous, active-high reset
//   in_valid     in   1       in_bit/in_sof valid this cycle
//   in_sof       in   1       start of frame, qualified by in_valid
//   in_bit       in   1       serial bit: data LSB first, then parity
//   out_data     out  DATA_W  data word of the last completed frame
//   out_valid    out  1       one-cycle pulse: out_data/out_par_err updated
//   out_par_err  out  1       parity mismatch for the word in out_data
//   busy         out  1       frame in progress (RECV or PAR)
//   frame_cnt    out  CNT_W   completed frames, saturating
//   err_cnt      out  CNT_W   completed frames with parity error, saturating

module serial_parity_checker #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic              in_bit,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_par_err,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int                BC_W     = $clog2(DATA_W);
    localparam logic [BC_W-1:0]   LAST_BIT = BC_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [BC_W-1:0]   BC_ONE   = BC_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [DATA_W-1:0] shift_reg;
    logic [BC_W-1:0]   bit_cnt;
    logic              acc;

    logic              start_frame;
    logic              shift_en;
    logic              par_take;
    logic              par_err;

    // A qualified start-of-frame wins in every state: in RECV/PAR it silently
    // drops the partial frame and restarts with this bit as data bit 0.
    assign start_frame = in_valid & in_sof;
    assign par_err     = (acc ^ in_bit) != PARITY_ODD;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        par_take  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_frame) begin
                    state_nxt = ST_RECV;
                end
            end
            ST_RECV: begin
                if (start_frame) begin
                    state_nxt = ST_RECV;
                end else if (in_valid) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = ST_PAR;
                    end
                end
            end
            ST_PAR: begin
                if (start_frame) begin
                    state_nxt = ST_RECV;
                end else if (in_valid) begin
                    par_take  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Data enters at the MSB and shifts right, so after DATA_W bits the first
    // (LSB) bit has arrived at position 0 and the word is aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            acc         <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_par_err <= 1'b0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
        end else begin
            out_valid <= 1'b0;
            if (start_frame) begin
                shift_reg <= {in_bit, {(DATA_W-1){1'b0}}};
                acc       <= in_bit;
                bit_cnt   <= BC_ONE;
            end else if (shift_en) begin
                shift_reg <= {in_bit, shift_reg[DATA_W-1:1]};
                acc       <= acc ^ in_bit;
                bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BC_ONE;
            end else if (par_take) begin
                out_data    <= shift_reg;
                out_par_err <= par_err;
                out_valid   <= 1'b1;
                acc         <= 1'b0;
                bit_cnt     <= '0;
                if (frame_cnt != CNT_MAX) begin
                    frame_cnt <= frame_cnt + CNT_ONE;
                end
                if (par_err && (err_cnt != CNT_MAX)) begin
                    err_cnt <= err_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule
